pong_ai_paddle_driver: RTL
==========================

# pong_ai_paddle_driver

Computer-controlled opponent for single-player Pong. Sits on the command side of a paddle controller. It watches ball position, ball direction and the paddle's current Y (all in game-board units), and drives up/down commands with the same meaning as the player button inputs. Reaction latency and a deadband keep it beatable.

## Interface
Parameters:
- c_GAME_HEIGHT, 30, board height in rows.
- c_PADDLE_HEIGHT, 6, paddle height in rows.
- c_REACTION_TIME, 2500000, clocks spent in WAIT before each decision (must be ≥1).
- c_DEADBAND, 1, allowed |center − target| error in rows that produces no movement.

Ports:
- i_Clk  in  1  system clock; single clock domain.
- i_Rst  in  1  synchronous reset, active-high.
- i_Enable  in  1  AI owns this paddle (single-player mode).
- i_Game_Active  in  1  ball in play.
- i_Ball_Y  in  6  ball row.
- i_Ball_Dir_X  in  1  1 = ball moving toward this paddle.
- i_Paddle_Y  in  6  paddle top row, from the paddle controller.
- o_Paddle_Up  out  1  move-up command, registered.
- o_Paddle_Dn  out  1  move-down command, registered.
- o_State  out  2  current FSM state, for debug.

## Operation
- center = i_Paddle_Y + c_PADDLE_HEIGHT/2, computed at 7 bits with no wrap.
- target = i_Ball_Y when i_Ball_Dir_X=1, else c_GAME_HEIGHT/2. Target is evaluated live every cycle.
- Bottom limit Y_MAX = c_GAME_HEIGHT − c_PADDLE_HEIGHT − 1.
- FSM states: IDLE=0, WAIT=1, MOVE_UP=2, MOVE_DN=3.
- IDLE: both outputs 0, counter 0. Goes to WAIT when i_Enable & i_Game_Active.
- WAIT: counter increments each cycle. When counter = c_REACTION_TIME−1, the decision is made on that edge and the counter clears:
  - center > target + c_DEADBAND and i_Paddle_Y ≠ 0 → MOVE_UP.
  - center + c_DEADBAND < target and i_Paddle_Y ≠ Y_MAX → MOVE_DN.
  - Otherwise stay in WAIT and restart the count.
- MOVE_UP: o_Paddle_Up=1. Exits to WAIT (counter 0) when center ≤ target + c_DEADBAND or i_Paddle_Y = 0.
- MOVE_DN: o_Paddle_Dn=1. Exits to WAIT (counter 0) when center + c_DEADBAND ≥ target or i_Paddle_Y = Y_MAX.
- Direction change: any toggle of i_Ball_Dir_X (versus a registered copy) in WAIT or a MOVE state forces WAIT with counter 0. The reaction delay restarts.
- Abort: i_Enable=0 or i_Game_Active=0 in any state → IDLE.
- Priority, highest first: i_Rst, then abort, then direction change, then normal transitions.
- o_Paddle_Up and o_Paddle_Dn are never both 1.

## Timing
- Reset values: state IDLE, counter 0, o_Paddle_Up=0, o_Paddle_Dn=0, o_State=0, registered direction = 0.
- Outputs are registered together with the state and change on the same edge the state changes.
- Decision latency: a command asserts exactly c_REACTION_TIME clocks after WAIT entry.
- MOVE exit takes 1 clock after the exit condition is present on the inputs.
- Abort or reset mid-move: outputs are 0 on the next edge.
- Counter is 32 bits and never wraps, because it clears at c_REACTION_TIME−1.

## Test plan
Benches use c_REACTION_TIME=4 and defaults otherwise.
- Reset: hold i_Rst with i_Enable=1 and i_Game_Active=1 → outputs 0, o_State=0. Release → o_State=1 after the next edge.
- Track down: Dir=1, Ball_Y=20, Paddle_Y=5 (center 8) → o_Paddle_Dn=1 on the 4th edge in WAIT. Step Paddle_Y to 16 (center 19) → Dn drops 1 clock later, o_State=1.
- Recenter: Dir=0, Paddle_Y=20 (center 23), target 15 → o_Paddle_Up=1 after 4 clocks. Falls when Paddle_Y=13.
- Deadband: Dir=1, Paddle_Y=13 (center 16), Ball_Y=17 → no command over 20 clocks; FSM stays in WAIT.
- Wall: Dir=1, Paddle_Y=23, Ball_Y=29 → o_Paddle_Dn never asserts. From Paddle_Y=22 in MOVE_DN, stepping to 23 → Dn drops next edge.
- Interrupts: toggle Dir during MOVE_DN → Dn=0 next edge, and the new command comes 4 clocks later. Deassert i_Game_Active during MOVE_UP → o_State=0 and outputs 0 next edge.

Source files
------------

// File: rtl/pong_ai_paddle_driver.sv
// AI opponent for single-player Pong: waits a reaction delay, then steps the
// paddle toward the ball (or back to mid-board) until inside a deadband.
module pong_ai_paddle_driver #(
  parameter int c_GAME_HEIGHT   = 30,
  parameter int c_PADDLE_HEIGHT = 6,
  parameter int c_REACTION_TIME = 2500000,
  parameter int c_DEADBAND      = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  input  logic       i_Game_Active,
  input  logic [5:0] i_Ball_Y,
  input  logic       i_Ball_Dir_X,
  input  logic [5:0] i_Paddle_Y,
  output logic       o_Paddle_Up,
  output logic       o_Paddle_Dn,
  output logic [1:0] o_State
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    MOVE_UP = 2'd2,
    MOVE_DN = 2'd3
  } state_t;

  localparam logic [7:0]  HALF_PADDLE = 8'(c_PADDLE_HEIGHT / 2);
  localparam logic [7:0]  MID_BOARD   = 8'(c_GAME_HEIGHT / 2);
  localparam logic [7:0]  DEADBAND    = 8'(c_DEADBAND);
  localparam logic [5:0]  Y_MAX       = 6'(c_GAME_HEIGHT - c_PADDLE_HEIGHT - 1);
  localparam logic [31:0] CNT_LAST    = 32'(c_REACTION_TIME - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        up_q, up_d;
  logic        dn_q, dn_d;
  logic        dir_q;

  logic [7:0] center;
  logic [7:0] target;
  logic       want_up, want_dn;
  logic       dir_changed;

  // Extra headroom bit so center + deadband can never wrap.
  assign center      = {2'b00, i_Paddle_Y} + HALF_PADDLE;
  assign target      = i_Ball_Dir_X ? {2'b00, i_Ball_Y} : MID_BOARD;
  assign want_up     = (center > target + DEADBAND) && (i_Paddle_Y != '0);
  assign want_dn     = (center + DEADBAND < target) && (i_Paddle_Y != Y_MAX);
  assign dir_changed = i_Ball_Dir_X != dir_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!i_Enable || !i_Game_Active) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q != IDLE && dir_changed) begin
      state_d = WAIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT;
          cnt_d   = '0;
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (want_up)      state_d = MOVE_UP;
            else if (want_dn) state_d = MOVE_DN;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        MOVE_UP: begin
          if (!want_up) begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
        MOVE_DN: begin
          if (!want_dn) begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    up_d = (state_d == MOVE_UP);
    dn_d = (state_d == MOVE_DN);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      dir_q   <= i_Ball_Dir_X;
    end
  end

  assign o_Paddle_Up = up_q;
  assign o_Paddle_Dn = dn_q;
  assign o_State     = state_q;

endmodule
